// File: rtl/seg7_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg7_io_ctrl
// Description : Bus-side register block for the 8-digit seven-segment driver.
//               CPU writes land in shadow registers and are committed to the
//               live outputs only at a scan-frame boundary (or on an explicit
//               commit write). Also generates the digit scan index and the
//               blink clock.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_io_ctrl #(
    parameter int SCAN_TC      = 50000,
    parameter int FLASH_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_req,
    input  logic [1:0]  addr,
    input  logic [31:0] Data_in,
    output logic        wr_ack,
    output logic [31:0] Hexs,
    output logic [7:0]  point,
    output logic [7:0]  LES,
    output logic [2:0]  Scan,
    output logic        flash,
    output logic        dirty
);

    localparam int PW = (SCAN_TC > 1) ? $clog2(SCAN_TC) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [PW-1:0] c_ps_last      = PW'(SCAN_TC - 1);
    localparam logic [FW-1:0] c_frm_last     = FW'(FLASH_FRAMES - 1);
    localparam logic [1:0]    c_addr_hexs    = 2'd0;
    localparam logic [1:0]    c_addr_point   = 2'd1;
    localparam logic [1:0]    c_addr_les     = 2'd2;
    localparam logic [1:0]    c_addr_commit  = 2'd3;

    logic [PW-1:0] ps_q,     ps_d;
    logic [2:0]    scan_q,   scan_d;
    logic [FW-1:0] frm_q,    frm_d;
    logic          flash_q,  flash_d;
    logic          ack_q,    ack_d;
    logic          dirty_q,  dirty_d;
    logic [31:0]   sh_hexs_q,  sh_hexs_d;
    logic [7:0]    sh_point_q, sh_point_d;
    logic [7:0]    sh_les_q,   sh_les_d;
    logic [31:0]   hexs_q,   hexs_d;
    logic [7:0]    point_q,  point_d;
    logic [7:0]    les_q,    les_d;

    logic w_step;
    logic w_frame;
    logic w_accept;
    logic w_force;
    logic w_commit;

    // Next-state logic: prescaler, scan, blink, write accept and commit.
    always_comb begin
        w_step   = (ps_q == c_ps_last);
        w_frame  = w_step && (scan_q == 3'd7);
        // The ack cycle blocks re-acceptance of a request still held high.
        w_accept = wr_req && !ack_q;
        w_force  = w_accept && (addr == c_addr_commit);
        w_commit = (w_frame && dirty_q) || w_force;

        ps_d   = w_step ? '0 : ps_q + PW'(1);
        scan_d = w_step ? scan_q + 3'd1 : scan_q;

        frm_d   = frm_q;
        flash_d = flash_q;
        if (w_frame) begin
            if (frm_q == c_frm_last) begin
                frm_d   = '0;
                flash_d = ~flash_q;
            end else begin
                frm_d = frm_q + FW'(1);
            end
        end

        ack_d = w_accept;

        // Commit copies the shadow as it stood before this edge, so a write
        // landing on the same edge is deferred to the next frame.
        hexs_d  = hexs_q;
        point_d = point_q;
        les_d   = les_q;
        dirty_d = dirty_q;
        if (w_commit) begin
            hexs_d  = sh_hexs_q;
            point_d = sh_point_q;
            les_d   = sh_les_q;
            dirty_d = 1'b0;
        end

        sh_hexs_d  = sh_hexs_q;
        sh_point_d = sh_point_q;
        sh_les_d   = sh_les_q;
        if (w_accept) begin
            case (addr)
                c_addr_hexs: begin
                    sh_hexs_d = Data_in;
                    dirty_d   = 1'b1;
                end
                c_addr_point: begin
                    sh_point_d = Data_in[7:0];
                    dirty_d    = 1'b1;
                end
                c_addr_les: begin
                    sh_les_d = Data_in[7:0];
                    dirty_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q       <= '0;
            scan_q     <= '0;
            frm_q      <= '0;
            flash_q    <= 1'b0;
            ack_q      <= 1'b0;
            dirty_q    <= 1'b0;
            sh_hexs_q  <= '0;
            sh_point_q <= '0;
            sh_les_q   <= '0;
            hexs_q     <= '0;
            point_q    <= '0;
            les_q      <= '0;
        end else begin
            ps_q       <= ps_d;
            scan_q     <= scan_d;
            frm_q      <= frm_d;
            flash_q    <= flash_d;
            ack_q      <= ack_d;
            dirty_q    <= dirty_d;
            sh_hexs_q  <= sh_hexs_d;
            sh_point_q <= sh_point_d;
            sh_les_q   <= sh_les_d;
            hexs_q     <= hexs_d;
            point_q    <= point_d;
            les_q      <= les_d;
        end
    end

    assign wr_ack = ack_q;
    assign Hexs   = hexs_q;
    assign point  = point_q;
    assign LES    = les_q;
    assign Scan   = scan_q;
    assign flash  = flash_q;
    assign dirty  = dirty_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_io_ctrl
// Description : Directed self-checking bench for seg7_io_ctrl with
//               SCAN_TC=4, FLASH_FRAMES=2. Cycle k is the cycle whose
//               closing rising edge is the (k+1)-th edge after reset release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_io_ctrl;

    localparam int SCAN_TC      = 4;
    localparam int FLASH_FRAMES = 2;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        wr_req  = 1'b0;
    logic [1:0]  addr    = 2'd0;
    logic [31:0] Data_in = 32'd0;
    logic        wr_ack;
    logic [31:0] Hexs;
    logic [7:0]  point;
    logic [7:0]  LES;
    logic [2:0]  Scan;
    logic        flash;
    logic        dirty;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    seg7_io_ctrl #(
        .SCAN_TC      (SCAN_TC),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_req  (wr_req),
        .addr    (addr),
        .Data_in (Data_in),
        .wr_ack  (wr_ack),
        .Hexs    (Hexs),
        .point   (point),
        .LES     (LES),
        .Scan    (Scan),
        .flash   (flash),
        .dirty   (dirty)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance to just after the edge that closes cycle k.
    task automatic goto(input int k);
        while (cyc < k + 1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        wr_req  = 1'b0;
        addr    = 2'd0;
        Data_in = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic test_reset();
        logic [2:0] exp_scan;
        rst_n  = 1'b0;
        wr_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({wr_ack, Hexs, point, LES, Scan, flash, dirty} !== 54'd0) begin
            miscompares++;
            $display("FAIL reset_outputs got %h exp 0",
                     {wr_ack, Hexs, point, LES, Scan, flash, dirty});
        end
        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 0; k < 32; k++) begin
            goto(k);
            exp_scan = 3'(((k + 1) / SCAN_TC) % 8);
            vectors++;
            if (Scan !== exp_scan) begin
                miscompares++;
                $display("FAIL reset_scan cyc=%0d got %0d exp %0d", k, Scan, exp_scan);
            end
        end
    endtask

    task automatic test_flash();
        logic [2:0] exp_scan;
        logic       exp_flash;
        apply_reset();
        for (int k = 0; k < 200; k++) begin
            goto(k);
            exp_scan  = 3'(((k + 1) / SCAN_TC) % 8);
            exp_flash = 1'(((k + 1) / (8 * SCAN_TC * FLASH_FRAMES)) % 2);
            vectors++;
            if (Scan !== exp_scan) begin
                miscompares++;
                $display("FAIL flash_scan cyc=%0d got %0d exp %0d", k, Scan, exp_scan);
            end
            vectors++;
            if (flash !== exp_flash) begin
                miscompares++;
                $display("FAIL flash_phase cyc=%0d got %0d exp %0d", k, flash, exp_flash);
            end
        end
    endtask

    task automatic test_deferred_commit();
        apply_reset();
        goto(4);
        wr_req = 1'b1; addr = 2'd0; Data_in = 32'h1234ABCD;
        goto(5);
        vectors++;
        if ({wr_ack, dirty} !== 2'b11) begin
            miscompares++;
            $display("FAIL defer_ack_dirty got %b exp 11", {wr_ack, dirty});
        end
        vectors++;
        if (Hexs !== 32'd0) begin
            miscompares++;
            $display("FAIL defer_hexs_early got %h exp 0", Hexs);
        end
        wr_req = 1'b0;
        goto(6);
        vectors++;
        if (wr_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL defer_ack_single got %b exp 0", wr_ack);
        end
        goto(30);
        vectors++;
        if ({Hexs, dirty} !== {32'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL defer_pre_frame got %h/%b exp 0/1", Hexs, dirty);
        end
        goto(31);
        vectors++;
        if ({Hexs, dirty} !== {32'h1234ABCD, 1'b0}) begin
            miscompares++;
            $display("FAIL defer_commit got %h/%b exp 1234abcd/0", Hexs, dirty);
        end
    endtask

    task automatic test_forced_commit();
        apply_reset();
        goto(1);
        wr_req = 1'b1; addr = 2'd1; Data_in = 32'hFFFFFF0F;
        goto(2);
        vectors++;
        if ({wr_ack, dirty, point} !== {2'b11, 8'h00}) begin
            miscompares++;
            $display("FAIL force_shadow got %b/%h exp 11/00", {wr_ack, dirty}, point);
        end
        wr_req = 1'b0;
        goto(3);
        wr_req = 1'b1; addr = 2'd3; Data_in = 32'hFFFFFFFF;
        goto(4);
        vectors++;
        if ({wr_ack, dirty, point} !== {2'b10, 8'h0F}) begin
            miscompares++;
            $display("FAIL force_commit got %b/%h exp 10/0f", {wr_ack, dirty}, point);
        end
        vectors++;
        if ({Hexs, LES} !== 40'd0) begin
            miscompares++;
            $display("FAIL force_other_regs got %h/%h exp 0/0", Hexs, LES);
        end
        wr_req = 1'b0;
    endtask

    task automatic test_write_on_frame();
        apply_reset();
        goto(9);
        wr_req = 1'b1; addr = 2'd2; Data_in = 32'h000000AA;
        goto(10);
        vectors++;
        if ({dirty, LES} !== {1'b1, 8'h00}) begin
            miscompares++;
            $display("FAIL wof_preload got %b/%h exp 1/00", dirty, LES);
        end
        wr_req = 1'b0;
        goto(30);
        wr_req = 1'b1; addr = 2'd2; Data_in = 32'h00000055;
        goto(31);
        vectors++;
        if ({wr_ack, dirty, LES} !== {2'b11, 8'hAA}) begin
            miscompares++;
            $display("FAIL wof_frame_edge got %b/%h exp 11/aa", {wr_ack, dirty}, LES);
        end
        wr_req = 1'b0;
        goto(62);
        vectors++;
        if (LES !== 8'hAA) begin
            miscompares++;
            $display("FAIL wof_hold got %h exp aa", LES);
        end
        goto(63);
        vectors++;
        if ({dirty, LES} !== {1'b0, 8'h55}) begin
            miscompares++;
            $display("FAIL wof_next_frame got %b/%h exp 0/55", dirty, LES);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic exp_ack;
        apply_reset();
        goto(1);
        wr_req = 1'b1; addr = 2'd0; Data_in = 32'hDEADBEEF;
        for (int k = 2; k <= 8; k++) begin
            goto(k);
            exp_ack = (k % 2 == 0);
            vectors++;
            if (wr_ack !== exp_ack) begin
                miscompares++;
                $display("FAIL b2b_ack cyc=%0d got %b exp %b", k, wr_ack, exp_ack);
            end
        end
        vectors++;
        if (dirty !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_dirty got %b exp 1", dirty);
        end
        // Mid-cycle reset during an ack cycle.
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({wr_ack, Hexs, point, LES, Scan, flash, dirty} !== 54'd0) begin
            miscompares++;
            $display("FAIL b2b_async_clear got %h exp 0",
                     {wr_ack, Hexs, point, LES, Scan, flash, dirty});
        end
        wr_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        goto(1);
        wr_req = 1'b1; addr = 2'd3; Data_in = 32'd0;
        goto(2);
        vectors++;
        if ({wr_ack, dirty, Hexs} !== {2'b10, 32'd0}) begin
            miscompares++;
            $display("FAIL b2b_no_write got %b/%h exp 10/0", {wr_ack, dirty}, Hexs);
        end
        wr_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_flash();
        test_deferred_commit();
        test_forced_commit();
        test_write_on_frame();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
